am2909_next_addr_ctl: RTL
=========================

Name: am2909_next_addr_ctl

Overview:
Next-address controller that sequences one or more cascaded Am2909 slices, in the same role as an Am2910 control block.
- Decodes a 4-bit microinstruction opcode and a condition input.
- Drives the 2909 control pins: S, FE, PUP, RE, ZERO, C.
- Drives active-low source enables for the D bus (pipeline, map, vector).
- Owns the loop counter and a stack-depth tracker.

Parameters:
CW, 12, loop counter width (matches three cascaded 4-bit slices).
STACK_DEPTH, 4, depth of the 2909 push/pop file tracked by the controller.

Ports:
CP  in  1  clock; all state updates on posedge.
CLR  in  1  asynchronous, active-low reset.
INSTR  in  4  opcode, 0x0–0xF.
CC_N  in  1  condition, active-low (0 = true).
CCEN_N  in  1  condition enable, active-low; when 1, the condition is forced to pass.
LD_VAL  in  CW  counter load value (same D-bus value the 2909 sees).
S  out  2  2909 source select: 00 µPC, 01 R, 10 stack, 11 D.
FE  out  1  file enable, active-low.
PUP  out  1  1 = push, 0 = pop.
RE  out  1  2909 R-register enable, active-low.
ZERO  out  1  1 forces 2909 Y to 0.
C  out  1  µPC increment carry-in; 1 = advance.
PL_N, MAP_N, VECT_N  out  1 each  D-bus source enables, active-low, exactly one low per cycle.
FULL_N  out  1  0 when tracked depth equals STACK_DEPTH.
CNT_ZERO  out  1  1 when counter equals 0.
ERR  out  1  sticky stack-overflow flag (see Optional Feature).

Behaviour:
- pass = CCEN_N | ~CC_N.
- All outputs are combinational from INSTR, pass, CNT and DEPTH. CNT and DEPTH update on posedge CP.
- Default per cycle: FE=1, PUP=1, RE=1, ZERO=0, C=1, PL_N=0, MAP_N=1, VECT_N=1.
- "push" means FE=0, PUP=1, DEPTH+1. "pop" means FE=0, PUP=0, DEPTH−1.
- Opcodes:
  - 0 JZ: S=11, ZERO=1, DEPTH←0.
  - 1 CJS: pass → S=11, push; else S=00.
  - 2 JMAP: S=11, MAP_N=0, PL_N=1.
  - 3 CJP: pass → S=11; else S=00.
  - 4 PUSH: push, S=00; if pass, CNT←LD_VAL and RE=0.
  - 5 JSRP: push; pass → S=11; else S=01.
  - 6 CJV: pass → S=11, VECT_N=0, PL_N=1; else S=00.
  - 7 JRP: pass → S=11; else S=01.
  - 8 RFCT: CNT≠0 → S=10, CNT−1; CNT=0 → S=00, pop.
  - 9 RPCT: CNT≠0 → S=11, CNT−1; else S=00.
  - A CRTN: pass → S=10, pop; else S=00.
  - B CJPP: pass → S=11, pop; else S=00.
  - C LDCT: S=00, CNT←LD_VAL, RE=0.
  - D LOOP: pass → S=00, pop; else S=10.
  - E CONT: S=00.
  - F TWB: pass → S=11, pop; fail with CNT≠0 → S=10, CNT−1; fail with CNT=0 → S=11, pop.
- Counter:
  - CW-bit, unsigned; loads truncate/zero-extend to CW.
  - Decrement is never issued at CNT=0, so there is no wrap.
- DEPTH:
  - Range 0..STACK_DEPTH.
  - Pop at DEPTH=0 holds 0; the 2909 pins are still driven as pop.
  - A push at full is governed by the Optional Feature.
- Reset (CLR=0, asynchronous, any time including mid-instruction):
  - State: CNT=0, DEPTH=0, ERR=0.
  - Outputs held at S=00, FE=1, PUP=1, RE=1, ZERO=1, C=0, PL_N=MAP_N=VECT_N=1, FULL_N=1.
  - First posedge after CLR rises executes INSTR normally.

Optional Feature:
Macro AM2909_CTL_STACK_GUARD_EN.
- Defined: a push while FULL_N=0 forces FE=1 (push suppressed); S is unaffected; DEPTH holds; ERR sets at that posedge and stays 1 until CLR.
- Undefined: a push at full drives FE=0, PUP=1 (the 2909 overwrites); DEPTH holds; ERR is tied to 0.

Decomposition:
- Package am2909_ctl_pkg: opcode localparams (OP_JZ..OP_TWB), S encodings (SEL_UPC, SEL_R, SEL_STK, SEL_D), STACK_DEPTH default.
- Sub-module am2909_loop_counter (load/decrement/zero-detect, CW-parameterised) is natural.
- Decode and depth tracking stay in the top module.

Test Plan:
1. Assert CLR=0 mid-cycle with CNT=5 → outputs immediately at reset values, CNT=0; after release, INSTR=E (CONT) → S=00, C=1.
2. LDCT with LD_VAL=3 (RE=0 that cycle), then RPCT ×4 → S=11,11,11,00; CNT_ZERO=1 after the third RPCT.
3. CJS with CC_N=0 ×4 → FE=0, PUP=1 each cycle, FULL_N=0 after the 4th. Fifth CJS:
   - guard defined: FE=1, ERR=1.
   - guard undefined: FE=0, ERR=0.
4. CRTN with CCEN_N=1 at DEPTH=1 → S=10, FE=0, PUP=0, DEPTH=0; second CRTN → DEPTH stays 0.
5. JMAP → MAP_N=0, PL_N=1, S=11; CJV with CC_N=1, CCEN_N=0 → S=00, VECT_N=1, PL_N=0.
6. TWB with CNT=1, CC_N=1, CCEN_N=0 → S=10, CNT=0 next cycle; repeat → S=11, pop; then JZ → ZERO=1, FULL_N=1, DEPTH=0.

Source files
------------

// File: rtl/am2909_ctl_pkg.sv
// am2909_ctl_pkg: opcodes, 2909 source-select encodings and default stack depth
package am2909_ctl_pkg;
    localparam logic [3:0] OP_JZ   = 4'h0;
    localparam logic [3:0] OP_CJS  = 4'h1;
    localparam logic [3:0] OP_JMAP = 4'h2;
    localparam logic [3:0] OP_CJP  = 4'h3;
    localparam logic [3:0] OP_PUSH = 4'h4;
    localparam logic [3:0] OP_JSRP = 4'h5;
    localparam logic [3:0] OP_CJV  = 4'h6;
    localparam logic [3:0] OP_JRP  = 4'h7;
    localparam logic [3:0] OP_RFCT = 4'h8;
    localparam logic [3:0] OP_RPCT = 4'h9;
    localparam logic [3:0] OP_CRTN = 4'hA;
    localparam logic [3:0] OP_CJPP = 4'hB;
    localparam logic [3:0] OP_LDCT = 4'hC;
    localparam logic [3:0] OP_LOOP = 4'hD;
    localparam logic [3:0] OP_CONT = 4'hE;
    localparam logic [3:0] OP_TWB  = 4'hF;
    localparam logic [1:0] SEL_UPC = 2'b00;
    localparam logic [1:0] SEL_R   = 2'b01;
    localparam logic [1:0] SEL_STK = 2'b10;
    localparam logic [1:0] SEL_D   = 2'b11;
    localparam int STACK_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/am2909_loop_counter.sv
// am2909_loop_counter: loadable down-counter with zero detect
module am2909_loop_counter #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic          dec,
    input  logic [CW-1:0] d,
    output logic          zero
);
    logic [CW-1:0] cnt;
    // load wins over decrement; decrement is only requested when non-zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= ld ? d : dec ? cnt - CW'(1) : cnt;
    assign zero = cnt == '0;
endmodule

// File: rtl/am2909_next_addr_ctl.sv
// am2909_next_addr_ctl: Am2910-style next-address control for cascaded Am2909 slices
// Optional stack-overflow guard: define AM2909_CTL_STACK_GUARD_EN
module am2909_next_addr_ctl
    import am2909_ctl_pkg::*;
#(
    parameter int CW          = 12,
    parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic          CP,
    input  logic          CLR,
    input  logic [3:0]    INSTR,
    input  logic          CC_N,
    input  logic          CCEN_N,
    input  logic [CW-1:0] LD_VAL,
    output logic [1:0]    S,
    output logic          FE,
    output logic          PUP,
    output logic          RE,
    output logic          ZERO,
    output logic          C,
    output logic          PL_N,
    output logic          MAP_N,
    output logic          VECT_N,
    output logic          FULL_N,
    output logic          CNT_ZERO,
    output logic          ERR
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    logic          pass, push, pop, ld, dec, jz, map, vect, full, cnt_zero, fe;
    logic [1:0]    sel;
    logic [DW-1:0] depth;
    assign pass = CCEN_N | ~CC_N;
    assign full = depth == DW'(STACK_DEPTH);
    // opcode decode into source select, stack action and counter action
    always_comb begin
        sel = SEL_UPC; push = 1'b0; pop = 1'b0; ld = 1'b0; dec = 1'b0;
        jz = 1'b0; map = 1'b0; vect = 1'b0;
        case (INSTR)
            OP_JZ:   begin sel = SEL_D; jz = 1'b1; end
            OP_CJS:  begin sel = pass ? SEL_D : SEL_UPC; push = pass; end
            OP_JMAP: begin sel = SEL_D; map = 1'b1; end
            OP_CJP:  sel = pass ? SEL_D : SEL_UPC;
            OP_PUSH: begin push = 1'b1; ld = pass; end
            OP_JSRP: begin sel = pass ? SEL_D : SEL_R; push = 1'b1; end
            OP_CJV:  begin sel = pass ? SEL_D : SEL_UPC; vect = pass; end
            OP_JRP:  sel = pass ? SEL_D : SEL_R;
            OP_RFCT: begin sel = cnt_zero ? SEL_UPC : SEL_STK; dec = ~cnt_zero; pop = cnt_zero; end
            OP_RPCT: begin sel = cnt_zero ? SEL_UPC : SEL_D; dec = ~cnt_zero; end
            OP_CRTN: begin sel = pass ? SEL_STK : SEL_UPC; pop = pass; end
            OP_CJPP: begin sel = pass ? SEL_D : SEL_UPC; pop = pass; end
            OP_LDCT: ld = 1'b1;
            OP_LOOP: begin sel = pass ? SEL_UPC : SEL_STK; pop = pass; end
            OP_CONT: sel = SEL_UPC;
            OP_TWB:  begin
                sel = (pass | cnt_zero) ? SEL_D : SEL_STK;
                pop = pass | cnt_zero;
                dec = ~pass & ~cnt_zero;
            end
            default: sel = SEL_UPC;
        endcase
    end
`ifdef AM2909_CTL_STACK_GUARD_EN
    logic err_q;
    assign fe  = ~((push & ~full) | pop);
    assign ERR = err_q;
    // overflow flag is sticky until reset
    always_ff @(posedge CP or negedge CLR)
        if (!CLR) err_q <= 1'b0;
        else if (push & full) err_q <= 1'b1;
`else
    assign fe  = ~(push | pop);
    assign ERR = 1'b0;
`endif
    // depth tracking: saturate at both ends, JZ clears
    always_ff @(posedge CP or negedge CLR)
        if (!CLR) depth <= '0;
        else if (jz) depth <= '0;
        else if (push & ~full) depth <= depth + DW'(1);
        else if (pop & depth != '0) depth <= depth - DW'(1);
    am2909_loop_counter #(.CW(CW)) u_cnt (
        .clk  (CP),
        .rst_n(CLR),
        .ld   (ld),
        .dec  (dec),
        .d    (LD_VAL),
        .zero (cnt_zero)
    );
    assign S        = CLR ? sel : SEL_UPC;
    assign FE       = CLR ? fe : 1'b1;
    assign PUP      = CLR ? ~pop : 1'b1;
    assign RE       = CLR ? ~ld : 1'b1;
    assign ZERO     = CLR ? jz : 1'b1;
    assign C        = CLR;
    assign PL_N     = CLR ? (map | vect) : 1'b1;
    assign MAP_N    = CLR ? ~map : 1'b1;
    assign VECT_N   = CLR ? ~vect : 1'b1;
    assign FULL_N   = CLR ? ~full : 1'b1;
    assign CNT_ZERO = cnt_zero;
endmodule
